// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, NOP encoding, opcodes, fetch FSM states.
// Imported by the fetch stage files.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with next-PC selection: redirect, +4 (wrapping), or hold.
module fetch_pc_gen #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);
    import riscv_pkg::*;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Redirect outranks advance; the add simply drops the carry out.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect)
            w_pc_next = i_target;
        else if (i_advance)
            w_pc_next = r_pc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch with single-outstanding imem handshake and skid.
// Optional misaligned-target trap reporting: FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_sel_i,
    input  logic [XLEN-1:0] alu_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            if_misalign_o,
`endif
    output logic [31:0]     if_instr_o
);
    import riscv_pkg::*;

    fetch_state_t    r_state;
    logic            r_kill;
    logic [31:0]     r_skid;
    logic            r_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_instr;

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_target;
    logic            w_load_mem;
    logic            w_load_skid;
    logic            w_advance;
    logic            w_mis_load;
    logic            w_req_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_mis;
    logic r_mis_pend;
    logic r_mis_out;

    assign w_target   = alu_target_i;
    assign w_req_ok   = !r_mis;
    assign w_mis_load = r_mis_pend && (r_state == FETCH)
                        && !stall_i && !pc_sel_i;

    // Sticky until the next redirect; the trap slot is presented once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis      <= 1'b0;
            r_mis_pend <= 1'b0;
        end else if (pc_sel_i) begin
            r_mis      <= |alu_target_i[1:0];
            r_mis_pend <= |alu_target_i[1:0];
        end else if (w_mis_load) begin
            r_mis_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mis_out <= 1'b0;
        else if (pc_sel_i)
            r_mis_out <= 1'b0;
        else if (!stall_i)
            r_mis_out <= w_mis_load;
    end

    assign if_misalign_o = r_mis_out;
`else
    assign w_target   = alu_target_i & ~XLEN'(3);
    assign w_req_ok   = 1'b1;
    assign w_mis_load = 1'b0;
`endif

    assign w_load_mem  = (r_state == WAIT) && imem_rvalid_i && !r_kill
                         && !stall_i && !pc_sel_i;
    assign w_load_skid = (r_state == HOLD) && !stall_i && !pc_sel_i;
    assign w_advance   = w_load_mem || w_load_skid;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_redirect (pc_sel_i),
        .i_target   (w_target),
        .i_advance  (w_advance),
        .o_pc       (w_pc)
    );

    assign imem_req_o  = (r_state == FETCH) && w_req_ok;
    assign imem_addr_o = w_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_kill  <= 1'b0;
            r_skid  <= NOP_INSTR;
        end else begin
            unique case (r_state)
                BOOT: r_state <= FETCH;
                FETCH: begin
                    if (imem_req_o && imem_gnt_i) begin
                        r_state <= WAIT;
                        r_kill  <= pc_sel_i;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        r_kill <= 1'b0;
                        if (r_kill || pc_sel_i || !stall_i) begin
                            r_state <= FETCH;
                        end else begin
                            r_state <= HOLD;
                            r_skid  <= imem_rdata_i;
                        end
                    end else if (pc_sel_i) begin
                        r_kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pc_sel_i || !stall_i)
                        r_state <= FETCH;
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_if_pc <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else if (pc_sel_i) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!stall_i) begin
            r_valid <= w_advance || w_mis_load;
            r_instr <= NOP_INSTR;
            if (w_advance || w_mis_load)
                r_if_pc <= w_pc;
            if (w_load_mem)
                r_instr <= imem_rdata_i;
            else if (w_load_skid)
                r_instr <= r_skid;
        end
    end

    assign if_valid_o = r_valid;
    assign if_pc_o    = r_if_pc;
    assign if_pc4_o   = r_if_pc + XLEN'(4);
    assign if_instr_o = r_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model pushes expected words,
// an IF/ID monitor pops and compares them as they are presented.
`timescale 1ns/1ps
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        pc_sel_i;
    logic [31:0] alu_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign_o;
    logic        mis2;
`endif

    logic        rst2_n;
    logic        gnt2;
    logic        rv2;
    logic [31:0] rd2;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic [31:0] instr2;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel_i      (pc_sel_i),
        .alu_target_i  (alu_target_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_pc4_o      (if_pc4_o),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misalign_o (if_misalign_o),
`endif
        .if_instr_o    (if_instr_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst2_n),
        .pc_sel_i      (1'b0),
        .alu_target_i  (32'h0),
        .stall_i       (1'b0),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_gnt_i    (gnt2),
        .imem_rvalid_i (rv2),
        .imem_rdata_i  (rd2),
        .if_valid_o    (valid2),
        .if_pc_o       (pc2),
        .if_pc4_o      (pc4_2),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misalign_o (mis2),
`endif
        .if_instr_o    (instr2)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bit          mem_auto  = 1'b0;
    bit          gnt_ok    = 1'b1;
    bit          drop_rsp  = 1'b0;
    bit          pend      = 1'b0;
    bit          last_stall = 1'b0;
    int          lat       = 0;
    int          wcnt      = 0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 5);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: grants every request, answers after lat extra cycles.
    always @(negedge clk) begin
        if (mem_auto) begin
            imem_rvalid_i = 1'b0;
            imem_gnt_i    = 1'b0;
            if (!rst_n) begin
                pend     = 1'b0;
                drop_rsp = 1'b0;
                m_pc     = 32'h0;
            end else begin
                if (pend) begin
                    if (wcnt > 0) begin
                        wcnt--;
                    end else begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i  = mem_word(pend_addr);
                        if (drop_rsp) begin
                            drop_rsp = 1'b0;
                        end else begin
                            exp_q.push_back(exp_t'{pc: pend_addr, instr: mem_word(pend_addr)});
                            m_pc = pend_addr + 32'd4;
                        end
                        pend = 1'b0;
                    end
                end
                if (imem_req_o && gnt_ok) begin
                    checks++;
                    if (imem_addr_o !== m_pc) begin
                        errors++;
                        $display("FAIL grant_addr got %h want %h", imem_addr_o, m_pc);
                    end
                    imem_gnt_i = 1'b1;
                    pend       = 1'b1;
                    pend_addr  = m_pc;
                    wcnt       = lat;
                end
            end
        end
    end

    always @(posedge clk) last_stall = stall_i;

    // IF/ID monitor: every freshly loaded valid slot must match the queue head.
    always @(negedge clk) begin
        if (rst_n && if_valid_o && !last_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected got pc %h instr %h want none", if_pc_o, if_instr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_pc_o !== e.pc || if_instr_o !== e.instr || if_pc4_o !== e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL ifid_order got pc %h pc4 %h instr %h want pc %h instr %h",
                             if_pc_o, if_pc4_o, if_instr_o, e.pc, e.instr);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; pc_sel_i = 1'b0; alu_target_i = 32'h0; stall_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        mem_auto = 1'b1; gnt_ok = 1'b1; lat = 0;
        repeat (2) tick();
        checks++;
        if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid_o); end
        checks++;
        if (if_instr_o !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", if_instr_o, NOP); end
        checks++;
        if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", if_pc_o); end
        checks++;
        if (if_pc4_o !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h want 4", if_pc4_o); end
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0050_0093) begin
            errors++;
            $display("FAIL first_fetch got v %b pc %h instr %h want v 1 pc 0 instr 00500093",
                     if_valid_o, if_pc_o, if_instr_o);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL next_addr got req %b addr %h want req 1 addr 4", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        repeat (20) begin
            tick();
            if (if_valid_o) n++;
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL throughput got %0d want 10", n); end
    endtask

    task automatic test_stall_skid();
        int k = 0;
        logic [31:0] hold_pc;
        while (!if_valid_o && k < 20) begin tick(); k++; end
        checks++;
        if (!if_valid_o) begin errors++; $display("FAIL stall_sync got timeout want valid"); end
        hold_pc = m_pc - 32'd4;
        stall_i = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== hold_pc || if_instr_o !== mem_word(hold_pc)
                || imem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got v %b pc %h instr %h req %b want v 1 pc %h instr %h req 0",
                         if_valid_o, if_pc_o, if_instr_o, imem_req_o, hold_pc, mem_word(hold_pc));
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== hold_pc + 32'd4
            || if_instr_o !== mem_word(hold_pc + 32'd4)) begin
            errors++;
            $display("FAIL skid_release got v %b pc %h instr %h want v 1 pc %h",
                     if_valid_o, if_pc_o, if_instr_o, hold_pc + 32'd4);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== hold_pc + 32'd8) begin
            errors++;
            $display("FAIL skid_next_addr got %h want %h", imem_addr_o, hold_pc + 32'd8);
        end
    endtask

    task automatic test_redirect_wait();
        int k = 0;
        lat = 2;
        while (!(imem_req_o === 1'b0 && pend && imem_rvalid_i === 1'b0) && k < 20) begin
            tick(); k++;
        end
        checks++;
        if (k >= 20) begin errors++; $display("FAIL redir_sync got timeout want WAIT"); end
        pc_sel_i = 1'b1; alu_target_i = 32'h100; drop_rsp = 1'b1; m_pc = 32'h100;
        tick();
        pc_sel_i = 1'b0;
        checks++;
        if (if_valid_o !== 1'b0 || if_instr_o !== NOP) begin
            errors++;
            $display("FAIL redir_bubble got v %b instr %h want v 0 instr %h", if_valid_o, if_instr_o, NOP);
        end
        k = 0;
        while (imem_req_o !== 1'b1 && k < 20) begin tick(); k++; end
        lat = 0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL redir_addr got req %b addr %h want req 1 addr 100", imem_req_o, imem_addr_o);
        end
        checks++;
        if (if_valid_o !== 1'b0 || if_instr_o !== NOP) begin
            errors++;
            $display("FAIL kill_discard got v %b instr %h want v 0 instr %h", if_valid_o, if_instr_o, NOP);
        end
    endtask

    task automatic test_redirect_stall();
        int k = 0;
        logic [31:0] hold_pc;
        while (!if_valid_o && k < 20) begin tick(); k++; end
        checks++;
        if (!if_valid_o) begin errors++; $display("FAIL rs_sync got timeout want valid"); end
        hold_pc  = m_pc - 32'd4;
        stall_i  = 1'b1;
        drop_rsp = 1'b1;
        m_pc     = 32'h200;
        tick();
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== hold_pc) begin
            errors++;
            $display("FAIL rs_hold got v %b pc %h want v 1 pc %h", if_valid_o, if_pc_o, hold_pc);
        end
        pc_sel_i = 1'b1; alu_target_i = 32'h203;
        tick();
        pc_sel_i = 1'b0; stall_i = 1'b0; gnt_ok = 1'b0;
        checks++;
        if (if_valid_o !== 1'b0 || if_instr_o !== NOP) begin
            errors++;
            $display("FAIL rs_bubble got v %b instr %h want v 0 instr %h", if_valid_o, if_instr_o, NOP);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL rs_target got req %b addr %h want req 1 addr 200", imem_req_o, imem_addr_o);
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0 || pend) begin
            errors++;
            $display("FAIL drain got %0d queued want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_q.delete(); pend = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rm_fetch got req %b addr %h want req 1 addr 0", imem_req_o, imem_addr_o);
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid_o !== 1'b0 || if_instr_o !== NOP || if_pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_async got v %b instr %h pc %h req %b want v 0 instr %h pc 0 req 0",
                     if_valid_o, if_instr_o, if_pc_o, imem_req_o, NOP);
        end
        tick();
        rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        checks++;
        if (if_valid_o !== 1'b0 || if_instr_o !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rm_stray got v %b instr %h req %b addr %h want v 0 instr %h req 1 addr 0",
                     if_valid_o, if_instr_o, imem_req_o, imem_addr_o, NOP);
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        exp_q.push_back(exp_t'{pc: 32'h0, instr: mem_word(32'h0)});
        imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== mem_word(32'h0)
            || imem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL rm_refetch got v %b pc %h instr %h addr %h want v 1 pc 0 addr 4",
                     if_valid_o, if_pc_o, if_instr_o, imem_addr_o);
        end
    endtask

    task automatic test_wrap();
        tick();
        checks++;
        if (pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rst got pc %h pc4 %h v %b want pc fffffffc pc4 0 v 0", pc2, pc4_2, valid2);
        end
        rst2_n = 1'b1;
        tick();
        checks++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req got req %b addr %h want req 1 addr fffffffc", req2, addr2);
        end
        gnt2 = 1'b1;
        tick();
        gnt2 = 1'b0; rv2 = 1'b1; rd2 = 32'h0010_0073;
        tick();
        rv2 = 1'b0;
        checks++;
        if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || instr2 !== 32'h0010_0073) begin
            errors++;
            $display("FAIL wrap_load got v %b pc %h pc4 %h instr %h want v 1 pc fffffffc pc4 0 instr 00100073",
                     valid2, pc2, pc4_2, instr2);
        end
        checks++;
        if (req2 !== 1'b1 || addr2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got req %b addr %h want req 1 addr 0", req2, addr2);
        end
    endtask

    initial begin
        rst2_n = 1'b0; gnt2 = 1'b0; rv2 = 1'b0; rd2 = 32'h0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_stall();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
